// File: rtl/alu_issue_pkg.sv
// Shared types and defaults for the alu issue/write-back stage.
package alu_issue_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  localparam int OPCODE_W   = 2;
  localparam int DEF_WIDTH  = 4;
  localparam int DEF_FLAG_W = 5;
  localparam int DEF_NREGS  = 8;

endpackage

// File: rtl/alu_issue_ctrl_regfile.sv
// Register file: one synchronous write port (write-back beats debug on the same
// entry), two operand read ports and a debug read port; r0 is hard-wired to 0.
module alu_regfile
  import alu_issue_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREGS = DEF_NREGS,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_wb_we,
  input  logic [AW-1:0]    i_wb_addr,
  input  logic [WIDTH-1:0] i_wb_data,
  input  logic             i_dbg_we,
  input  logic [AW-1:0]    i_dbg_addr,
  input  logic [WIDTH-1:0] i_dbg_data,
  input  logic [AW-1:0]    i_ra_addr,
  output logic [WIDTH-1:0] o_ra_data,
  input  logic [AW-1:0]    i_rb_addr,
  output logic [WIDTH-1:0] o_rb_data,
  input  logic [AW-1:0]    i_dbg_raddr,
  output logic [WIDTH-1:0] o_dbg_rdata
);

  logic [WIDTH-1:0] r_mem [NREGS];

  // Entry 0 is never written, so it keeps its reset value of zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (i_wb_we && (i_wb_addr == AW'(i))) begin
          r_mem[i] <= i_wb_data;
        end else if (i_dbg_we && (i_dbg_addr == AW'(i))) begin
          r_mem[i] <= i_dbg_data;
        end
      end
    end
  end

  assign o_ra_data   = (i_ra_addr   == '0) ? '0 : r_mem[i_ra_addr];
  assign o_rb_data   = (i_rb_addr   == '0) ? '0 : r_mem[i_rb_addr];
  assign o_dbg_rdata = (i_dbg_raddr == '0) ? '0 : r_mem[i_dbg_raddr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/write-back stage around a combinational alu: IDLE accepts and reads
// operands, EXEC captures the alu result, WB writes it back and commits flags.
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NREGS  = DEF_NREGS,
  parameter int FLAG_W = DEF_FLAG_W,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [OPCODE_W-1:0] instr_op,
  input  logic [AW-1:0]       instr_rd,
  input  logic [AW-1:0]       instr_ra,
  input  logic [AW-1:0]       instr_rb,
  input  logic                instr_imm_en,
  input  logic [WIDTH-1:0]    instr_imm,
  output logic [WIDTH-1:0]    alu_a,
  output logic [WIDTH-1:0]    alu_b,
  output logic [OPCODE_W-1:0] alu_opcode,
  input  logic [WIDTH-1:0]    alu_c,
  input  logic [FLAG_W-1:0]   alu_flags,
  output logic                wb_valid,
  output logic [AW-1:0]       wb_rd,
  output logic [WIDTH-1:0]    wb_data,
  output logic [FLAG_W-1:0]   flags_q,
  input  logic                dbg_we,
  input  logic [AW-1:0]       dbg_waddr,
  input  logic [WIDTH-1:0]    dbg_wdata,
  input  logic [AW-1:0]       dbg_raddr,
  output logic [WIDTH-1:0]    dbg_rdata
);

  state_t r_state;
  state_t w_state_nxt;

  logic                w_accept;
  logic                w_wb_valid;
  logic [WIDTH-1:0]    w_ra_data;
  logic [WIDTH-1:0]    w_rb_data;

  logic [WIDTH-1:0]    r_a_p0;
  logic [WIDTH-1:0]    r_b_p0;
  logic [OPCODE_W-1:0] r_op_p0;
  logic [AW-1:0]       r_rd_p0;
  logic [WIDTH-1:0]    r_wb_data_p1;
  logic [FLAG_W-1:0]   r_flags_p1;
  logic [FLAG_W-1:0]   r_flags_q_p2;

  assign instr_ready = (r_state == IDLE) && !reset;
  assign w_accept    = instr_valid && instr_ready;
  assign w_wb_valid  = (r_state == WB) && !reset;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = EXEC;
      EXEC:    w_state_nxt = WB;
      WB:      w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  alu_regfile #(
    .WIDTH (WIDTH),
    .NREGS (NREGS),
    .AW    (AW)
  ) u_rf (
    .clk         (clk),
    .reset       (reset),
    .i_wb_we     (w_wb_valid),
    .i_wb_addr   (r_rd_p0),
    .i_wb_data   (r_wb_data_p1),
    .i_dbg_we    (dbg_we),
    .i_dbg_addr  (dbg_waddr),
    .i_dbg_data  (dbg_wdata),
    .i_ra_addr   (instr_ra),
    .o_ra_data   (w_ra_data),
    .i_rb_addr   (instr_rb),
    .o_rb_data   (w_rb_data),
    .i_dbg_raddr (dbg_raddr),
    .o_dbg_rdata (dbg_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a_p0       <= '0;
      r_b_p0       <= '0;
      r_op_p0      <= '0;
      r_rd_p0      <= '0;
      r_wb_data_p1 <= '0;
      r_flags_p1   <= '0;
      r_flags_q_p2 <= '0;
    end else begin
      // p0: operands latched on accept, held as alu inputs until the next accept
      if (w_accept) begin
        r_a_p0  <= w_ra_data;
        r_b_p0  <= instr_imm_en ? instr_imm : w_rb_data;
        r_op_p0 <= instr_op;
        r_rd_p0 <= instr_rd;
      end
      // p1: alu result and flags captured at the end of EXEC
      if (r_state == EXEC) begin
        r_wb_data_p1 <= alu_c;
        r_flags_p1   <= alu_flags;
      end
      // p2: flags committed alongside the register write-back
      if (r_state == WB) begin
        r_flags_q_p2 <= r_flags_p1;
      end
    end
  end

  assign alu_a      = r_a_p0;
  assign alu_b      = r_b_p0;
  assign alu_opcode = r_op_p0;
  assign wb_valid   = w_wb_valid;
  assign wb_rd      = r_rd_p0;
  assign wb_data    = r_wb_data_p1;
  assign flags_q    = r_flags_q_p2;

endmodule
